// File: rtl/wav_dfi_upd_lp_arbiter_if.sv
// Sideband handshake bundle between the MC-side DFI arbiter, the command scheduler and the DFI agent.
// master = arbiter view, slave = scheduler/PHY view.
interface wav_dfi_upd_lp_arbiter_if;
   logic       init_start;
   logic       traffic_idle;
   logic       cmd_stall;
   logic       mc_ctrlupd_req;
   logic       mc_lp_req;
   logic [5:0] mc_lp_wakeup;
   logic       ctrlupd_req;
   logic       ctrlupd_ack;
   logic       phyupd_req;
   logic [1:0] phyupd_type;
   logic       phyupd_ack;
   logic       phymstr_req;
   logic       phymstr_ack;
   logic       lp_ctrl_req;
   logic       lp_data_req;
   logic [5:0] lp_ctrl_wakeup;
   logic [5:0] lp_data_wakeup;
   logic       lp_ctrl_ack;
   logic       lp_data_ack;
   logic [1:0] upd_type;
   logic       err_phyupd_to;
   logic       err_lp_to;

   modport master (
      input  init_start, traffic_idle, mc_ctrlupd_req, mc_lp_req, mc_lp_wakeup,
             ctrlupd_ack, phyupd_req, phyupd_type, phymstr_req, lp_ctrl_ack, lp_data_ack,
      output cmd_stall, ctrlupd_req, phyupd_ack, phymstr_ack, lp_ctrl_req, lp_data_req,
             lp_ctrl_wakeup, lp_data_wakeup, upd_type, err_phyupd_to, err_lp_to
   );

   modport slave (
      output init_start, traffic_idle, mc_ctrlupd_req, mc_lp_req, mc_lp_wakeup,
             ctrlupd_ack, phyupd_req, phyupd_type, phymstr_req, lp_ctrl_ack, lp_data_ack,
      input  cmd_stall, ctrlupd_req, phyupd_ack, phymstr_ack, lp_ctrl_req, lp_data_req,
             lp_ctrl_wakeup, lp_data_wakeup, upd_type, err_phyupd_to, err_lp_to
   );
endinterface

// File: rtl/wav_dfi_upd_lp_arbiter.sv
// MC-side DFI sideband sequencer: one update / PHY-master / low-power handshake at a time.
// Define WAV_DFI_ARB_PHYMSTR_EN to include the PHY-master handshake.
//
// state   | meaning
// IDLE    | no handshake, cmd_stall low, waiting for a request
// DRAIN   | cmd_stall high, waiting for traffic_idle before granting
// CTRLUPD | ctrlupd_req driven; once dropped, waits for ctrlupd_ack low
// PHYUPD  | phyupd_ack driven until phyupd_req falls
// PHYMSTR | phymstr_ack driven until phymstr_req falls (optional)
// LP_REQ  | lp_*_req driven, waiting for both acks or timeout
// LP_ACT  | low power entered, holding reqs until mc_lp_req falls
// LP_EXIT | reqs dropped, waiting for both acks low
module wav_dfi_upd_lp_arbiter #(
   parameter int TLP_RESP     = 8,
   parameter int TPHYUPD_RESP = 16,
   parameter int TCTRLUPD_MIN = 4,
   parameter int TCTRLUPD_MAX = 32,
   parameter int CNT_W        = 8
) (
   input logic                      clock,
   input logic                      reset,
   wav_dfi_upd_lp_arbiter_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      CTRLUPD,
      PHYUPD,
`ifdef WAV_DFI_ARB_PHYMSTR_EN
      PHYMSTR,
`endif
      LP_REQ,
      LP_ACT,
      LP_EXIT
   } state_t;

   state_t             state;
   state_t             next_grant;
   logic [CNT_W-1:0]   timer;
   logic [CNT_W-1:0]   phy_timer;
   logic               cmd_stall_q;
   logic               ctrlupd_req_q;
   logic               phyupd_ack_q;
   logic               lp_req_q;
   logic [5:0]         wakeup_q;
   logic [1:0]         upd_type_q;
   logic               err_phyupd_q;
   logic               err_lp_q;
   logic               ctrl_pend;
   logic               ack_seen;
   logic               lp_done;
   logic               ctrl_ack_any;

`ifdef WAV_DFI_ARB_PHYMSTR_EN
   logic               phymstr_ack_q;
   assign bus.phymstr_ack = phymstr_ack_q;
`else
   assign bus.phymstr_ack = 1'b0;
`endif

   assign bus.cmd_stall      = cmd_stall_q;
   assign bus.ctrlupd_req    = ctrlupd_req_q;
   assign bus.phyupd_ack     = phyupd_ack_q;
   assign bus.lp_ctrl_req    = lp_req_q;
   assign bus.lp_data_req    = lp_req_q;
   assign bus.lp_ctrl_wakeup = wakeup_q;
   assign bus.lp_data_wakeup = wakeup_q;
   assign bus.upd_type       = upd_type_q;
   assign bus.err_phyupd_to  = err_phyupd_q;
   assign bus.err_lp_to      = err_lp_q;

   assign ctrl_ack_any = ack_seen || bus.ctrlupd_ack;

   // Controller updates are captured in ctrl_pend so a single-cycle pulse is still served.
   always_comb begin
      next_grant = IDLE;
      if (bus.phyupd_req)
         next_grant = PHYUPD;
      else if (ctrl_pend || bus.mc_ctrlupd_req)
         next_grant = CTRLUPD;
      else if (bus.mc_lp_req && !lp_done)
         next_grant = LP_REQ;
`ifdef WAV_DFI_ARB_PHYMSTR_EN
      if (bus.phymstr_req)
         next_grant = PHYMSTR;
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         timer         <= '0;
         phy_timer     <= '0;
         cmd_stall_q   <= 1'b0;
         ctrlupd_req_q <= 1'b0;
         phyupd_ack_q  <= 1'b0;
         lp_req_q      <= 1'b0;
         wakeup_q      <= '0;
         upd_type_q    <= '0;
         err_phyupd_q  <= 1'b0;
         err_lp_q      <= 1'b0;
         ctrl_pend     <= 1'b0;
         ack_seen      <= 1'b0;
         lp_done       <= 1'b0;
`ifdef WAV_DFI_ARB_PHYMSTR_EN
         phymstr_ack_q <= 1'b0;
`endif
      end else begin
         err_lp_q <= 1'b0;
         if (timer != '1)
            timer <= timer + 1'b1;
         if (bus.mc_ctrlupd_req && state != CTRLUPD)
            ctrl_pend <= 1'b1;
         if (!bus.mc_lp_req)
            lp_done <= 1'b0;

         // Response timer runs from phyupd_req rise until our ack
         if (!bus.phyupd_req || phyupd_ack_q)
            phy_timer <= '0;
         else if (phy_timer != '1)
            phy_timer <= phy_timer + 1'b1;
         if (bus.phyupd_req && !phyupd_ack_q && phy_timer == CNT_W'(TPHYUPD_RESP))
            err_phyupd_q <= 1'b1;

         case (state)
            IDLE: begin
               if (!bus.init_start && next_grant != IDLE) begin
                  state       <= DRAIN;
                  timer       <= '0;
                  cmd_stall_q <= 1'b1;
               end
            end
            DRAIN: begin
               if (bus.init_start || next_grant == IDLE) begin
                  state       <= IDLE;
                  timer       <= '0;
                  cmd_stall_q <= 1'b0;
               end else if (bus.traffic_idle) begin
                  state <= next_grant;
                  timer <= '0;
                  case (next_grant)
                     PHYUPD: begin
                        phyupd_ack_q <= 1'b1;
                        upd_type_q   <= bus.phyupd_type;
                     end
                     CTRLUPD: begin
                        ctrlupd_req_q <= 1'b1;
                        ctrl_pend     <= 1'b0;
                        ack_seen      <= 1'b0;
                     end
                     LP_REQ: begin
                        lp_req_q <= 1'b1;
                        wakeup_q <= bus.mc_lp_wakeup;
                     end
`ifdef WAV_DFI_ARB_PHYMSTR_EN
                     PHYMSTR: phymstr_ack_q <= 1'b1;
`endif
                     default: ;
                  endcase
               end
            end
            CTRLUPD: begin
               if (ctrlupd_req_q) begin
                  if (bus.ctrlupd_ack)
                     ack_seen <= 1'b1;
                  if (timer == CNT_W'(TCTRLUPD_MAX - 1) ||
                      (ctrl_ack_any && timer >= CNT_W'(TCTRLUPD_MIN - 1) && !bus.mc_ctrlupd_req))
                     ctrlupd_req_q <= 1'b0;
               end else if (!bus.ctrlupd_ack) begin
                  state       <= IDLE;
                  timer       <= '0;
                  cmd_stall_q <= 1'b0;
               end
            end
            PHYUPD: begin
               if (!bus.phyupd_req) begin
                  phyupd_ack_q <= 1'b0;
                  state        <= IDLE;
                  timer        <= '0;
                  cmd_stall_q  <= 1'b0;
               end
            end
`ifdef WAV_DFI_ARB_PHYMSTR_EN
            PHYMSTR: begin
               if (!bus.phymstr_req) begin
                  phymstr_ack_q <= 1'b0;
                  state         <= IDLE;
                  timer         <= '0;
                  cmd_stall_q   <= 1'b0;
               end
            end
`endif
            LP_REQ: begin
               if (bus.lp_ctrl_ack && bus.lp_data_ack) begin
                  state <= LP_ACT;
                  timer <= '0;
               end else if (timer == CNT_W'(TLP_RESP - 1)) begin
                  lp_req_q <= 1'b0;
                  err_lp_q <= 1'b1;
                  lp_done  <= 1'b1;
                  state    <= LP_EXIT;
                  timer    <= '0;
               end
            end
            LP_ACT: begin
               if (!bus.mc_lp_req) begin
                  lp_req_q <= 1'b0;
                  state    <= LP_EXIT;
                  timer    <= '0;
               end
            end
            LP_EXIT: begin
               if (!bus.lp_ctrl_ack && !bus.lp_data_ack) begin
                  state       <= IDLE;
                  timer       <= '0;
                  cmd_stall_q <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               timer <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wav_dfi_upd_lp_arbiter.sv
// Directed bench for wav_dfi_upd_lp_arbiter; expectations are hand-derived cycle counts.
module tb_wav_dfi_upd_lp_arbiter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   int   n;

   wav_dfi_upd_lp_arbiter_if b ();
   wav_dfi_upd_lp_arbiter dut (.clock(clock), .reset(reset), .bus(b));

   always #5 clock = ~clock;

   function automatic logic [3:0] grants();
      return {b.lp_ctrl_req | b.lp_data_req, b.phymstr_ack, b.phyupd_ack, b.ctrlupd_req};
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic [3:0] g_prev;
      g_prev = grants();
      @(posedge clock);
      #1;
      chk("exclusive", {7'd0, ($countones(grants()) <= 1)}, 8'd1);
      if (b.init_start)
         chk("init_no_rise", {4'd0, grants() & ~g_prev}, 8'd0);
   endtask

   task automatic wait_grant(input string tag, input logic [3:0] exp, input int max);
      int i;
      i = 0;
      while (grants() !== exp && i < max) begin
         step();
         i++;
      end
      chk(tag, {4'd0, grants()}, {4'd0, exp});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench stalled");
   end

   initial begin
      b.init_start = 0; b.traffic_idle = 0; b.mc_ctrlupd_req = 0; b.mc_lp_req = 0;
      b.mc_lp_wakeup = 0; b.ctrlupd_ack = 0; b.phyupd_req = 0; b.phyupd_type = 0;
      b.phymstr_req = 0; b.lp_ctrl_ack = 0; b.lp_data_ack = 0;
      step(); step();
      chk("rst_grants", {4'd0, grants()}, 8'd0);
      chk("rst_stall", {7'd0, b.cmd_stall}, 8'd0);
      chk("rst_errs", {6'd0, b.err_phyupd_to, b.err_lp_to}, 8'd0);
      chk("rst_wakeup", {2'd0, b.lp_ctrl_wakeup}, 8'd0);
      reset = 0;
      step();

      // 1: PHY update latency
      b.phyupd_req = 1; b.traffic_idle = 1; b.phyupd_type = 2'b10;
      step();
      chk("t1_stall_t1", {7'd0, b.cmd_stall}, 8'd1);
      chk("t1_noack_t1", {7'd0, b.phyupd_ack}, 8'd0);
      step();
      chk("t1_ack_t2", {7'd0, b.phyupd_ack}, 8'd1);
      chk("t1_upd_type", {6'd0, b.upd_type}, 8'd2);
      for (int i = 0; i < 8; i++) step();
      b.phyupd_req = 0;
      chk("t1_ack_t10", {7'd0, b.phyupd_ack}, 8'd1);
      step();
      chk("t1_ack_low_t11", {7'd0, b.phyupd_ack}, 8'd0);
      chk("t1_stall_low", {7'd0, b.cmd_stall}, 8'd0);
      chk("t1_no_err", {7'd0, b.err_phyupd_to}, 8'd0);

      // request dropped while draining is abandoned
      b.traffic_idle = 0; b.phyupd_req = 1;
      step();
      chk("abandon_stall", {7'd0, b.cmd_stall}, 8'd1);
      b.phyupd_req = 0;
      step();
      chk("abandon_idle", {7'd0, b.cmd_stall}, 8'd0);
      step();
      chk("abandon_nogrant", {4'd0, grants()}, 8'd0);

      // 2a: pulse, ack 2 cycles after req -> held exactly MIN
      b.traffic_idle = 1; b.mc_ctrlupd_req = 1;
      step();
      b.mc_ctrlupd_req = 0;
      chk("t2_not_yet", {7'd0, b.ctrlupd_req}, 8'd0);
      step();
      n = 0;
      while (b.ctrlupd_req && n < 40) begin
         n++;
         if (n == 3) b.ctrlupd_ack = 1;
         step();
      end
      chk("t2_min_len", 8'(n), 8'd4);
      b.ctrlupd_ack = 0;
      step();
      chk("t2_idle", {7'd0, b.cmd_stall}, 8'd0);

      // 2b: pulse with late traffic_idle, no ack -> held MAX
      b.traffic_idle = 0; b.mc_ctrlupd_req = 1;
      step();
      b.mc_ctrlupd_req = 0;
      step();
      chk("t2b_drain_stall", {7'd0, b.cmd_stall}, 8'd1);
      chk("t2b_drain_nogrant", {4'd0, grants()}, 8'd0);
      b.traffic_idle = 1;
      step();
      n = 0;
      while (b.ctrlupd_req && n < 40) begin
         n++;
         step();
      end
      chk("t2b_max_len", 8'(n), 8'd32);
      step();
      chk("t2b_idle", {7'd0, b.cmd_stall}, 8'd0);

      // 3: LP request timeout
      b.mc_lp_req = 1; b.mc_lp_wakeup = 6'h0A;
      step(); step();
      chk("t3_data_req", {7'd0, b.lp_data_req}, 8'd1);
      n = 0;
      while (b.lp_ctrl_req && n < 20) begin
         n++;
         step();
      end
      chk("t3_req_len", 8'(n), 8'd8);
      chk("t3_data_low", {7'd0, b.lp_data_req}, 8'd0);
      chk("t3_err_pulse", {7'd0, b.err_lp_to}, 8'd1);
      chk("t3_ctrl_wakeup", {2'd0, b.lp_ctrl_wakeup}, 8'h0A);
      chk("t3_data_wakeup", {2'd0, b.lp_data_wakeup}, 8'h0A);
      b.mc_lp_req = 0;
      step();
      chk("t3_err_once", {7'd0, b.err_lp_to}, 8'd0);
      chk("t3_idle", {7'd0, b.cmd_stall}, 8'd0);

      // 4: simultaneous requests served in priority order
      b.phymstr_req = 1; b.phyupd_req = 1; b.mc_ctrlupd_req = 1;
      step();
      b.mc_ctrlupd_req = 0;
`ifdef WAV_DFI_ARB_PHYMSTR_EN
      wait_grant("t4_mstr_first", 4'b0100, 4);
      step(); step(); step();
      b.phymstr_req = 0;
      wait_grant("t4_upd_second", 4'b0010, 6);
`else
      wait_grant("t4_upd_first", 4'b0010, 4);
`endif
      b.phymstr_req = 0;
      b.phyupd_req = 0;
      wait_grant("t4_ctrl_last", 4'b0001, 6);
      b.ctrlupd_ack = 1;
      wait_grant("t4_ctrl_drop", 4'b0000, 10);
      b.ctrlupd_ack = 0;
      step();
      chk("t4_idle", {7'd0, b.cmd_stall}, 8'd0);

      // 5: init_start blocks every grant
      b.init_start = 1;
      b.phymstr_req = 1; b.phyupd_req = 1; b.mc_ctrlupd_req = 1; b.mc_lp_req = 1;
      step();
      b.mc_ctrlupd_req = 0;
      for (int i = 0; i < 20; i++) step();
      chk("t5_no_grant", {4'd0, grants()}, 8'd0);
      chk("t5_no_stall", {7'd0, b.cmd_stall}, 8'd0);
      chk("t5_phyupd_to", {7'd0, b.err_phyupd_to}, 8'd1);
      b.init_start = 0;
`ifdef WAV_DFI_ARB_PHYMSTR_EN
      wait_grant("t5_mstr", 4'b0100, 4);
      b.phymstr_req = 0;
      wait_grant("t5_upd", 4'b0010, 6);
`else
      wait_grant("t5_upd", 4'b0010, 4);
`endif
      b.phymstr_req = 0;
      b.phyupd_req = 0;
      wait_grant("t5_ctrl", 4'b0001, 6);
      b.ctrlupd_ack = 1;
      wait_grant("t5_ctrl_drop", 4'b0000, 10);
      b.ctrlupd_ack = 0;
      wait_grant("t5_lp", 4'b1000, 8);
      b.lp_ctrl_ack = 1; b.lp_data_ack = 1;
      step(); step(); step();
      chk("t5_lp_act_hold", {4'd0, grants()}, 8'h08);

      // 6: async reset during LP_ACT
      #2;
      reset = 1;
      #1;
      chk("t6_lp_req_drop", {6'd0, b.lp_ctrl_req, b.lp_data_req}, 8'd0);
      chk("t6_stall_drop", {7'd0, b.cmd_stall}, 8'd0);
      chk("t6_err_clr", {7'd0, b.err_phyupd_to}, 8'd0);
      chk("t6_wakeup_clr", {2'd0, b.lp_data_wakeup}, 8'd0);
      b.mc_lp_req = 0; b.lp_ctrl_ack = 0; b.lp_data_ack = 0;
      step();
      reset = 0;
      step();
      b.phyupd_req = 1;
      step();
      chk("t6_idle_stall", {7'd0, b.cmd_stall}, 8'd1);
      step();
      chk("t6_idle_grant", {4'd0, grants()}, 8'h02);
      b.phyupd_req = 0;
      step();
      chk("t6_done", {7'd0, b.cmd_stall}, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
